// File: rtl/bank_gate_pkg.sv
// ---------------------------------------------------------------------------
// bank_gate_pkg
// Shared definitions for the bank write gate: the lock state machine
// encoding, default widths and the reset values of the registered outputs.
// Imported by bank_write_gate and bank_gate_sat_cnt.
// ---------------------------------------------------------------------------
package bank_gate_pkg;

    // OPEN: writes decoded normally.
    // LOCK_DRAIN: one cycle where the write accepted together with the lock completes.
    // LOCKED: every write is denied until reset.
    typedef enum logic [1:0] {
        OPEN       = 2'd0,
        LOCK_DRAIN = 2'd1,
        LOCKED     = 2'd2
    } gateState_e;

    localparam int DEFAULT_NUM_BANKS  = 2;
    localparam int DEFAULT_DATA_W     = 2;
    localparam int DEFAULT_BANK_IDX_W = 1;
    localparam int DEFAULT_CNT_W      = 8;

    localparam logic RST_RESP_VALID  = 1'b0;
    localparam logic RST_RESP_ERR    = 1'b0;
    localparam logic RST_LOCK_STATUS = 1'b0;

endpackage

// File: rtl/bank_gate_sat_cnt.sv
// ---------------------------------------------------------------------------
// bank_gate_sat_cnt
// Saturating up-counter with a synchronous clear. It holds at its all-ones
// value instead of wrapping.
// Ports:
//   clk      rising-edge clock
//   clear_i  synchronous clear, highest priority
//   inc_i    add one this cycle unless already saturated
//   count_o  current count
// ---------------------------------------------------------------------------
module bank_gate_sat_cnt
    import bank_gate_pkg::*;
#(
    parameter int WIDTH = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic             saturated;

    assign saturated = (count_q == {WIDTH{1'b1}});

    // Clear wins over increment. Once at all-ones the count sticks there.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            count_q <= '0;
        end else if (inc_i && !saturated) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bank_write_gate.sv
// ---------------------------------------------------------------------------
// bank_write_gate
// Write-control stage in front of an array of lockable register banks.
// A request is accepted on req_valid && req_ready. One cycle later it turns
// into a one-cycle per-bank write-enable pulse plus shared write data, and a
// one-cycle completion pulse. A single sticky lock denies writes to every
// bank uniformly. Only reset clears the lock.
//
// Optional feature macro: BANK_WRITE_GATE_DENY_CNT_EN
//   When defined, adds the deny_cnt port. This is a saturating count of
//   denied completions.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_bank, req_all     target bank index / broadcast to all banks
//   req_data              write data
//   lock_req              request to set the sticky lock
//   lock_status           high while LOCKED
//   bank_we, bank_wdata   write-enable pulses and data to the banks
//   resp_valid, resp_err  completion pulse and its denied flag
//   deny_cnt              denied-write count (feature macro only)
// ---------------------------------------------------------------------------
module bank_write_gate
    import bank_gate_pkg::*;
#(
    parameter int NUM_BANKS  = DEFAULT_NUM_BANKS,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int BANK_IDX_W = DEFAULT_BANK_IDX_W,
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [BANK_IDX_W-1:0] req_bank,
    input  logic                  req_all,
    input  logic [DATA_W-1:0]     req_data,
    input  logic                  lock_req,
    output logic                  lock_status,
    output logic [NUM_BANKS-1:0]  bank_we,
    output logic [DATA_W-1:0]     bank_wdata,
    output logic                  resp_valid,
    output logic                  resp_err
`ifdef BANK_WRITE_GATE_DENY_CNT_EN
    ,
    output logic [CNT_W-1:0]      deny_cnt
`endif
);

    localparam logic [NUM_BANKS-1:0] ONE_HOT_LSB = NUM_BANKS'(1);

    gateState_e            state_q, state_d;
    logic                  accepted;
    logic                  bankInRange;
    logic [NUM_BANKS-1:0]  weDecode;
    logic                  errDecode;

    logic [NUM_BANKS-1:0]  bankWe_q;
    logic [DATA_W-1:0]     bankWdata_q;
    logic                  respValid_q;
    logic                  respErr_q;
    logic                  lockStatus_q;

    // Ready is combinational on rst so nothing can be accepted in a reset
    // cycle. The drain cycle stalls so the lock is seen as atomic.
    assign req_ready = !rst && (state_q != LOCK_DRAIN);
    assign accepted  = req_valid && req_ready;

    assign bankInRange = (int'(req_bank) < NUM_BANKS);

    // Decode the request into bank enables. A lock or a bad index produces a
    // denial with no enables. Broadcast drives every bank in the same pulse.
    always_comb begin
        weDecode  = '0;
        errDecode = 1'b0;
        if (state_q == LOCKED) begin
            errDecode = 1'b1;
        end else if (req_all) begin
            weDecode = '1;
        end else if (bankInRange) begin
            weDecode = ONE_HOT_LSB << req_bank;
        end else begin
            errDecode = 1'b1;
        end
    end

    // Lock sequencing. A request accepted together with lock_req is honoured
    // first. The drain cycle then lets that write complete before LOCKED.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OPEN: begin
                if (lock_req) begin
                    state_d = accepted ? LOCK_DRAIN : LOCKED;
                end
            end
            LOCK_DRAIN: state_d = LOCKED;
            LOCKED:     state_d = LOCKED;
            default:    state_d = OPEN;
        endcase
    end

    // The output stage registers one cycle of effect per accepted request.
    // Reset drops any write that was about to be issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= OPEN;
            bankWe_q     <= '0;
            bankWdata_q  <= '0;
            respValid_q  <= RST_RESP_VALID;
            respErr_q    <= RST_RESP_ERR;
            lockStatus_q <= RST_LOCK_STATUS;
        end else begin
            state_q      <= state_d;
            bankWe_q     <= accepted ? weDecode : '0;
            respValid_q  <= accepted;
            respErr_q    <= accepted && errDecode;
            lockStatus_q <= (state_d == LOCKED);
            if (accepted) begin
                bankWdata_q <= req_data;
            end
        end
    end

    assign bank_we     = bankWe_q;
    assign bank_wdata  = bankWdata_q;
    assign resp_valid  = respValid_q;
    assign resp_err    = respErr_q;
    assign lock_status = lockStatus_q;

`ifdef BANK_WRITE_GATE_DENY_CNT_EN
    // Counts denied completions as they appear on the response outputs.
    bank_gate_sat_cnt #(
        .WIDTH (CNT_W)
    ) u_deny_cnt (
        .clk     (clk),
        .clear_i (rst),
        .inc_i   (respValid_q && respErr_q),
        .count_o (deny_cnt)
    );
`endif

endmodule
